// File: rtl/arbitro_memorias_acesso_externo_pkg.sv
// Shared widths and defaults for the external-access memory read arbiter.
// Widths match gerenciador_memorias_acesso_externo.
package arbitro_memorias_acesso_externo_pkg;

  localparam int ADDR_WIDTH_DEF          = 8;
  localparam int RELACOES_DATA_WIDTH_DEF = 8;
  localparam int N_REQ_DEF               = 2;

  // Width of a counter that holds 0..n, used for wrap arithmetic.
  function automatic int wrap_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/arbitro_memorias_acesso_externo_rr_arbiter.sv
// Round-robin grant generator with a registered rotation pointer.
// The grant is combinational from the pointer and the request vector.
module arbitro_memorias_acesso_externo_rr_arbiter
  import arbitro_memorias_acesso_externo_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] valid_i,
  input  logic             advance_i,
  output logic [N_REQ-1:0] grant_o
);

  localparam int PW = $clog2(N_REQ);
  localparam int SW = wrap_w(N_REQ);
  localparam logic [SW-1:0] NREQ_S = SW'(N_REQ);

  logic [PW-1:0] rr_ptr_q;
  logic [PW-1:0] rr_ptr_d;
  logic [PW-1:0] win;
  logic [PW-1:0] idx;
  logic [SW-1:0] sum;
  logic [SW-1:0] nxt;
  logic          found;

  // Scan from the pointer, wrapping, and keep the first valid.
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    win     = '0;
    idx     = '0;
    sum     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, rr_ptr_q} + SW'(k);
      if (sum >= NREQ_S) begin
        sum = sum - NREQ_S;
      end
      idx = sum[PW-1:0];
      if (!found && valid_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
        win          = idx;
      end
    end
  end

  always_comb begin
    nxt = {1'b0, win} + SW'(1);
    if (nxt == NREQ_S) begin
      rr_ptr_d = '0;
    end else begin
      rr_ptr_d = nxt[PW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else if (advance_i && found) begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/arbitro_memorias_acesso_externo.sv
// Shares the relacoes/obstaculos read ports among N_REQ requesters.
// Both memories are read at the granted address; results return tagged one cycle later.
module arbitro_memorias_acesso_externo
  import arbitro_memorias_acesso_externo_pkg::*;
#(
  parameter int ADDR_WIDTH          = ADDR_WIDTH_DEF,
  parameter int RELACOES_DATA_WIDTH = RELACOES_DATA_WIDTH_DEF,
  parameter int N_REQ               = N_REQ_DEF
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [N_REQ-1:0]                  req_valid_in,
  input  logic [N_REQ*ADDR_WIDTH-1:0]       req_addr_in,
  output logic [N_REQ-1:0]                  req_ready_out,
  output logic [N_REQ-1:0]                  rsp_valid_out,
  output logic [RELACOES_DATA_WIDTH-1:0]    rsp_relacoes_out,
  output logic                              rsp_obstaculo_out,
  output logic                              relacoes_rd_enable_out,
  output logic [ADDR_WIDTH-1:0]             relacoes_rd_addr_out,
  input  logic [RELACOES_DATA_WIDTH-1:0]    relacoes_rd_data_in,
  output logic                              obstaculos_rd_enable_out,
  output logic [ADDR_WIDTH-1:0]             obstaculos_rd_addr_out,
  input  logic                              obstaculos_rd_data_in
);

  logic [N_REQ-1:0]      grant;
  logic [N_REQ-1:0]      tag_q;
  logic [ADDR_WIDTH-1:0] addr_sel;
  logic                  any_grant;

  arbitro_memorias_acesso_externo_rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr_arbiter (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_i   (req_valid_in),
    .advance_i (any_grant),
    .grant_o   (grant)
  );

  assign any_grant = |grant;

  // Grant is one-hot, so OR-ing the masked addresses selects it.
  always_comb begin
    addr_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        addr_sel = addr_sel | req_addr_in[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  assign req_ready_out            = grant;
  assign relacoes_rd_enable_out   = any_grant;
  assign obstaculos_rd_enable_out = any_grant;
  assign relacoes_rd_addr_out     = addr_sel;
  assign obstaculos_rd_addr_out   = addr_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q <= '0;
    end else begin
      tag_q <= grant;
    end
  end

  assign rsp_valid_out     = tag_q;
  assign rsp_relacoes_out  = relacoes_rd_data_in;
  assign rsp_obstaculo_out = obstaculos_rd_data_in;

endmodule

// File: tb/tb_arbitro_memorias_acesso_externo.sv
// Self-checking bench: 1-cycle memory model plus a rotation reference model.
// A second N_REQ=3 instance covers pointer wrap.
module tb_arbitro_memorias_acesso_externo;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  req_valid;
  logic [15:0] req_addr;
  logic [1:0]  ready;
  logic [1:0]  rspv;
  logic [7:0]  rsp_rel;
  logic        rsp_obs;
  logic        rel_en;
  logic        obs_en;
  logic [7:0]  rel_addr;
  logic [7:0]  obs_addr;
  logic [7:0]  rel_rd;
  logic        obs_rd;

  logic [2:0]  valid3;
  logic [23:0] addr3;
  logic [2:0]  ready3;
  logic [2:0]  rspv3;
  logic [7:0]  rsp_rel3;
  logic        rsp_obs3;
  logic        rel_en3;
  logic        obs_en3;
  logic [7:0]  rel_addr3;
  logic [7:0]  obs_addr3;

  logic [7:0] mem_rel [256];
  logic       mem_obs [256];

  int errors = 0;
  int checks = 0;
  int m_ptr = 0;
  logic [1:0] m_tag = 2'b00;
  logic [7:0] m_addr = 8'h00;

  arbitro_memorias_acesso_externo u_dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .req_valid_in             (req_valid),
    .req_addr_in              (req_addr),
    .req_ready_out            (ready),
    .rsp_valid_out            (rspv),
    .rsp_relacoes_out         (rsp_rel),
    .rsp_obstaculo_out        (rsp_obs),
    .relacoes_rd_enable_out   (rel_en),
    .relacoes_rd_addr_out     (rel_addr),
    .relacoes_rd_data_in      (rel_rd),
    .obstaculos_rd_enable_out (obs_en),
    .obstaculos_rd_addr_out   (obs_addr),
    .obstaculos_rd_data_in    (obs_rd)
  );

  arbitro_memorias_acesso_externo #(
    .N_REQ (3)
  ) u_dut3 (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .req_valid_in             (valid3),
    .req_addr_in              (addr3),
    .req_ready_out            (ready3),
    .rsp_valid_out            (rspv3),
    .rsp_relacoes_out         (rsp_rel3),
    .rsp_obstaculo_out        (rsp_obs3),
    .relacoes_rd_enable_out   (rel_en3),
    .relacoes_rd_addr_out     (rel_addr3),
    .relacoes_rd_data_in      (8'h00),
    .obstaculos_rd_enable_out (obs_en3),
    .obstaculos_rd_addr_out   (obs_addr3),
    .obstaculos_rd_data_in    (1'b0)
  );

  always @(posedge clk) begin
    if (rel_en) rel_rd <= mem_rel[rel_addr];
    if (obs_en) obs_rd <= mem_obs[obs_addr];
  end

  // Reference: first valid requester at or after the pointer, wrapping.
  function automatic logic [1:0] m_grant(input logic [1:0] v, input int p);
    for (int k = 0; k < 2; k++) begin
      int i;
      i = (p + k) % 2;
      if (v[i]) return 2'(1 << i);
    end
    return 2'b00;
  endfunction

  task automatic apply(input logic [1:0] v, input logic [7:0] a0,
                       input logic [7:0] a1);
    @(negedge clk);
    req_valid = v;
    req_addr  = {a1, a0};
    #1;
  endtask

  task automatic tick();
    logic [1:0] g;
    g = m_grant(req_valid, m_ptr);
    @(posedge clk);
    m_tag = g;
    if (g[0]) begin
      m_addr = req_addr[7:0];
      m_ptr  = 1;
    end else if (g[1]) begin
      m_addr = req_addr[15:8];
      m_ptr  = 0;
    end
    #1;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    valid3    = '0;
    addr3     = '0;
    m_ptr     = 0;
    m_tag     = 2'b00;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (rspv !== 2'b00) begin
      errors++;
      $display("FAIL reset_rsp got %b exp 00", rspv);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      apply(2'b00, 8'h00, 8'h00);
      checks++;
      if (ready !== 2'b00) begin
        errors++;
        $display("FAIL idle_ready cyc %0d got %b exp 00", c, ready);
      end
      checks++;
      if ({rel_en, obs_en, rel_addr, obs_addr} !== 18'h0) begin
        errors++;
        $display("FAIL idle_bus cyc %0d got %h exp 0", c,
                 {rel_en, obs_en, rel_addr, obs_addr});
      end
      tick();
      checks++;
      if (rspv !== 2'b00) begin
        errors++;
        $display("FAIL idle_rsp cyc %0d got %b exp 00", c, rspv);
      end
    end
  endtask

  task automatic test_single();
    apply(2'b01, 8'h05, 8'h00);
    checks++;
    if (ready !== 2'b01) begin
      errors++;
      $display("FAIL single_ready got %b exp 01", ready);
    end
    checks++;
    if ({rel_en, obs_en, rel_addr, obs_addr} !== {2'b11, 8'h05, 8'h05}) begin
      errors++;
      $display("FAIL single_bus got %h exp %h",
               {rel_en, obs_en, rel_addr, obs_addr}, {2'b11, 8'h05, 8'h05});
    end
    tick();
    checks++;
    if ({rspv, rsp_rel, rsp_obs} !== {2'b01, 8'hA3, 1'b1}) begin
      errors++;
      $display("FAIL single_rsp got v=%b rel=%h obs=%b exp v=01 rel=a3 obs=1",
               rspv, rsp_rel, rsp_obs);
    end
    apply(2'b00, 8'h00, 8'h00);
    tick();
    checks++;
    if (rspv !== 2'b00) begin
      errors++;
      $display("FAIL single_done got %b exp 00", rspv);
    end
  endtask

  task automatic test_alternating();
    logic [1:0] exp;
    reset_dut();
    for (int c = 0; c < 8; c++) begin
      apply(2'b11, 8'h10, 8'h20);
      exp = m_grant(req_valid, m_ptr);
      checks++;
      if (ready !== exp) begin
        errors++;
        $display("FAIL alt_ready cyc %0d got %b exp %b", c, ready, exp);
      end
      checks++;
      if (rel_addr !== (exp[0] ? 8'h10 : 8'h20)) begin
        errors++;
        $display("FAIL alt_addr cyc %0d got %h exp %h", c, rel_addr,
                 exp[0] ? 8'h10 : 8'h20);
      end
      tick();
      checks++;
      if ({rspv, rsp_rel, rsp_obs} !==
          {m_tag, mem_rel[m_addr], mem_obs[m_addr]}) begin
        errors++;
        $display("FAIL alt_rsp cyc %0d got %b/%h/%b exp %b/%h/%b", c,
                 rspv, rsp_rel, rsp_obs, m_tag, mem_rel[m_addr],
                 mem_obs[m_addr]);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 1; k <= 3; k++) begin
      apply(2'b10, 8'h00, 8'(k));
      checks++;
      if ({ready, rel_addr} !== {2'b10, 8'(k)}) begin
        errors++;
        $display("FAIL b2b_grant k %0d got %b/%h exp 10/%h", k, ready,
                 rel_addr, 8'(k));
      end
      tick();
      checks++;
      if ({rspv, rsp_rel, rsp_obs} !== {2'b10, mem_rel[k], mem_obs[k]}) begin
        errors++;
        $display("FAIL b2b_rsp k %0d got %b/%h/%b exp 10/%h/%b", k, rspv,
                 rsp_rel, rsp_obs, mem_rel[k], mem_obs[k]);
      end
    end
    apply(2'b00, 8'h00, 8'h00);
    tick();
  endtask

  task automatic test_wrap3();
    reset_dut();
    @(negedge clk);
    valid3 = 3'b010;
    addr3  = {8'h33, 8'h22, 8'h11};
    #1;
    checks++;
    if (ready3 !== 3'b010) begin
      errors++;
      $display("FAIL wrap_first got %b exp 010", ready3);
    end
    @(negedge clk);
    valid3 = 3'b011;
    #1;
    checks++;
    if ({ready3, rel_addr3} !== {3'b001, 8'h11}) begin
      errors++;
      $display("FAIL wrap_grant got %b/%h exp 001/11", ready3, rel_addr3);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({ready3, rspv3} !== {3'b010, 3'b001}) begin
      errors++;
      $display("FAIL wrap_next got %b/%b exp 010/001", ready3, rspv3);
    end
    @(negedge clk);
    valid3 = 3'b000;
    @(posedge clk);
    m_tag = 2'b00;
  endtask

  task automatic test_reset_mid();
    reset_dut();
    apply(2'b01, 8'h07, 8'h00);
    checks++;
    if (ready !== 2'b01) begin
      errors++;
      $display("FAIL mid_grant got %b exp 01", ready);
    end
    tick();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = 2'b00;
    m_ptr     = 0;
    m_tag     = 2'b00;
    #1;
    checks++;
    if (rspv !== 2'b00) begin
      errors++;
      $display("FAIL mid_drop got %b exp 00", rspv);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    apply(2'b11, 8'h07, 8'h09);
    checks++;
    if (ready !== 2'b01) begin
      errors++;
      $display("FAIL mid_regain got %b exp 01", ready);
    end
    tick();
    checks++;
    if ({rspv, rsp_rel} !== {2'b01, mem_rel[8'h07]}) begin
      errors++;
      $display("FAIL mid_rsp got %b/%h exp 01/%h", rspv, rsp_rel,
               mem_rel[8'h07]);
    end
  endtask

  task automatic test_random();
    logic [1:0] v;
    logic [1:0] exp;
    logic [7:0] a [2];
    logic [7:0] ea;
    int         w [2];
    reset_dut();
    v = 2'b00;
    a[0] = 8'h00;
    a[1] = 8'h00;
    w[0] = 0;
    w[1] = 0;
    for (int c = 0; c < 400; c++) begin
      apply(v, a[0], a[1]);
      exp = m_grant(v, m_ptr);
      ea  = exp[0] ? a[0] : (exp[1] ? a[1] : 8'h00);
      checks++;
      if ({ready, rel_en, obs_en, rel_addr, obs_addr} !==
          {exp, |exp, |exp, ea, ea}) begin
        errors++;
        $display("FAIL rand_issue cyc %0d got %h exp %h", c,
                 {ready, rel_en, obs_en, rel_addr, obs_addr},
                 {exp, |exp, |exp, ea, ea});
      end
      tick();
      checks++;
      if (rspv !== m_tag ||
          (m_tag != 2'b00 && {rsp_rel, rsp_obs} !==
           {mem_rel[m_addr], mem_obs[m_addr]})) begin
        errors++;
        $display("FAIL rand_rsp cyc %0d got %b/%h/%b exp %b/%h/%b", c,
                 rspv, rsp_rel, rsp_obs, m_tag, mem_rel[m_addr],
                 mem_obs[m_addr]);
      end
      for (int i = 0; i < 2; i++) begin
        if (exp[i]) begin
          w[i] = 0;
        end else if (v[i] && exp != 2'b00) begin
          w[i]++;
          checks++;
          if (w[i] > 1) begin
            errors++;
            $display("FAIL rand_fair cyc %0d req %0d waited %0d exp <=1",
                     c, i, w[i]);
          end
        end
        if (!(v[i] && !exp[i])) begin
          v[i] = ($urandom % 4) != 0;
          a[i] = 8'($urandom);
        end
      end
    end
    apply(2'b00, 8'h00, 8'h00);
    tick();
  endtask

  initial begin
    req_valid = '0;
    req_addr  = '0;
    valid3    = '0;
    addr3     = '0;
    for (int i = 0; i < 256; i++) begin
      mem_rel[i] = 8'($urandom);
      mem_obs[i] = 1'($urandom_range(0, 1));
    end
    mem_rel[8'h05] = 8'hA3;
    mem_obs[8'h05] = 1'b1;
    test_reset();
    test_single();
    test_alternating();
    test_back_to_back();
    test_wrap3();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
